// File: rtl/bp_pkg.sv
// Shared types and helpers for the 2-bit saturating-counter branch predictor.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_t;

    localparam bp_cnt_t BP_CNT_RESET = WNT;

    typedef struct packed {
        logic valid;
        logic pred;
    } pred_slot_t;

    // Saturating step towards the observed outcome.
    function automatic bp_cnt_t bp_next(bp_cnt_t cur, logic taken);
        bp_cnt_t nxt;
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_pred_pipe.sv
// Carries {valid, pred} alongside the instruction through IF/ID and ID/EX.
module bp_pred_pipe
    import bp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       flush,
    input  logic       pred_if,
    output pred_slot_t slot_id,
    output pred_slot_t slot_ex
);

    // Flush beats stall; stall holds IF/ID and drops a bubble into ID/EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_id <= '0;
            slot_ex <= '0;
        end else if (flush) begin
            slot_id <= '0;
            slot_ex <= '0;
        end else if (stall) begin
            slot_ex <= '0;
        end else begin
            slot_id <= '{valid: 1'b1, pred: pred_if};
            slot_ex <= slot_id;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter beq predictor: lookup at IF, resolve and train at EX.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [PC_W-1:0]  PC_IF,
    input  logic [PC_W-1:0]  PC_EX,
    input  logic             STALL,
    input  logic             BEQ_EX,
    input  logic             BEQ_TAKEN_EX,
    output logic             PRED_TAKEN_IF,
    output logic             PRED_TAKEN_EX,
    output logic             BEQ_WRONG_PRED,
    output logic [CNT_W-1:0] BRANCH_CNT,
    output logic [CNT_W-1:0] MISPRED_CNT
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    bp_cnt_t          tbl [DEPTH];
    logic [IDX_W-1:0] idx_if;
    logic [IDX_W-1:0] idx_ex;
    pred_slot_t       slot_id;
    pred_slot_t       slot_ex;
    logic             resolve;
    logic             unused_pc_bits;

    assign idx_if = PC_IF[IDX_W+1:2];
    assign idx_ex = PC_EX[IDX_W+1:2];
    assign unused_pc_bits = ^{PC_IF[PC_W-1:IDX_W+2], PC_IF[1:0],
                              PC_EX[PC_W-1:IDX_W+2], PC_EX[1:0], slot_id};

    assign PRED_TAKEN_IF  = tbl[idx_if][1];
    assign PRED_TAKEN_EX  = slot_ex.pred;
    assign resolve        = BEQ_EX & slot_ex.valid;
    assign BEQ_WRONG_PRED = resolve & (slot_ex.pred != BEQ_TAKEN_EX);

    bp_pred_pipe u_pipe (
        .clk     (CLK),
        .rst     (RST),
        .stall   (STALL),
        .flush   (BEQ_WRONG_PRED),
        .pred_if (PRED_TAKEN_IF),
        .slot_id (slot_id),
        .slot_ex (slot_ex)
    );

    // Training happens regardless of STALL; lookups see it from the next cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl[i] <= BP_CNT_RESET;
            end
        end else if (resolve) begin
            tbl[idx_ex] <= bp_next(tbl[idx_ex], BEQ_TAKEN_EX);
        end
    end

    // Statistics saturate at all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BRANCH_CNT  <= '0;
            MISPRED_CNT <= '0;
        end else if (resolve) begin
            if (BRANCH_CNT != '1) begin
                BRANCH_CNT <= BRANCH_CNT + CNT_W'(1);
            end
            if (BEQ_WRONG_PRED && (MISPRED_CNT != '1)) begin
                MISPRED_CNT <= MISPRED_CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: training, stall bubbles, flush, aliasing, reset.
module tb_branch_predictor;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [PC_W-1:0] FILL = 32'h0000_0004;

    logic             CLK;
    logic             RST;
    logic [PC_W-1:0]  PC_IF;
    logic [PC_W-1:0]  PC_EX;
    logic             STALL;
    logic             BEQ_EX;
    logic             BEQ_TAKEN_EX;
    logic             PRED_TAKEN_IF;
    logic             PRED_TAKEN_EX;
    logic             BEQ_WRONG_PRED;
    logic [CNT_W-1:0] BRANCH_CNT;
    logic [CNT_W-1:0] MISPRED_CNT;

    int total;
    int bad;

    branch_predictor #(.IDX_W(4), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .PC_IF          (PC_IF),
        .PC_EX          (PC_EX),
        .STALL          (STALL),
        .BEQ_EX         (BEQ_EX),
        .BEQ_TAKEN_EX   (BEQ_TAKEN_EX),
        .PRED_TAKEN_IF  (PRED_TAKEN_IF),
        .PRED_TAKEN_EX  (PRED_TAKEN_EX),
        .BEQ_WRONG_PRED (BEQ_WRONG_PRED),
        .BRANCH_CNT     (BRANCH_CNT),
        .MISPRED_CNT    (MISPRED_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [PC_W-1:0] pif, input logic [PC_W-1:0] pex,
                         input logic stall, input logic beq, input logic taken);
        PC_IF        = pif;
        PC_EX        = pex;
        STALL        = stall;
        BEQ_EX       = beq;
        BEQ_TAKEN_EX = taken;
    endtask

    // One beq fetched alone, resolved two edges later, then statistics checked.
    task automatic run_beq(input string name, input logic [PC_W-1:0] pc, input logic taken,
                           input logic exp_pred, input logic exp_wrong,
                           input logic [CNT_W-1:0] exp_bc, input logic [CNT_W-1:0] exp_mc);
        drive(pc, '0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (PRED_TAKEN_IF !== exp_pred) begin bad++; $display("FAIL %s pred_if: got %b want %b", name, PRED_TAKEN_IF, exp_pred); end
        tick();
        drive(FILL, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(FILL, pc, 1'b0, 1'b1, taken);
        #1;
        total++; if (PRED_TAKEN_EX !== exp_pred) begin bad++; $display("FAIL %s pred_ex: got %b want %b", name, PRED_TAKEN_EX, exp_pred); end
        total++; if (BEQ_WRONG_PRED !== exp_wrong) begin bad++; $display("FAIL %s wrong: got %b want %b", name, BEQ_WRONG_PRED, exp_wrong); end
        tick();
        drive(FILL, '0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (BRANCH_CNT !== exp_bc) begin bad++; $display("FAIL %s branch_cnt: got %0d want %0d", name, BRANCH_CNT, exp_bc); end
        total++; if (MISPRED_CNT !== exp_mc) begin bad++; $display("FAIL %s mispred_cnt: got %0d want %0d", name, MISPRED_CNT, exp_mc); end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(32'h40, '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        RST = 1'b0;
        #1;
        total++; if (PRED_TAKEN_IF !== 1'b0) begin bad++; $display("FAIL reset pred_if: got %b want 0", PRED_TAKEN_IF); end
        total++; if (PRED_TAKEN_EX !== 1'b0) begin bad++; $display("FAIL reset pred_ex: got %b want 0", PRED_TAKEN_EX); end
        total++; if (BEQ_WRONG_PRED !== 1'b0) begin bad++; $display("FAIL reset wrong: got %b want 0", BEQ_WRONG_PRED); end
        total++; if (BRANCH_CNT !== '0) begin bad++; $display("FAIL reset branch_cnt: got %0d want 0", BRANCH_CNT); end
        total++; if (MISPRED_CNT !== '0) begin bad++; $display("FAIL reset mispred_cnt: got %0d want 0", MISPRED_CNT); end
    endtask

    task automatic test_train_taken();
        run_beq("taken1", 32'h40, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1);
        run_beq("taken2", 32'h40, 1'b1, 1'b1, 1'b0, 16'd2, 16'd1);
        run_beq("taken3", 32'h40, 1'b1, 1'b1, 1'b0, 16'd3, 16'd1);
    endtask

    task automatic test_train_not_taken();
        run_beq("ntaken1", 32'h40, 1'b0, 1'b1, 1'b1, 16'd4, 16'd2);
        run_beq("ntaken2", 32'h40, 1'b0, 1'b1, 1'b1, 16'd5, 16'd3);
    endtask

    task automatic test_stall();
        run_beq("stall_prep", 32'h48, 1'b1, 1'b0, 1'b1, 16'd6, 16'd4);
        drive(32'h48, '0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (PRED_TAKEN_IF !== 1'b1) begin bad++; $display("FAIL stall pred_if: got %b want 1", PRED_TAKEN_IF); end
        tick();
        drive(FILL, '0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(FILL, 32'h48, 1'b1, 1'b1, 1'b0);
        #1;
        total++; if (PRED_TAKEN_EX !== 1'b0) begin bad++; $display("FAIL stall bubble pred_ex: got %b want 0", PRED_TAKEN_EX); end
        total++; if (BEQ_WRONG_PRED !== 1'b0) begin bad++; $display("FAIL stall bubble1 wrong: got %b want 0", BEQ_WRONG_PRED); end
        tick();
        drive(FILL, 32'h48, 1'b0, 1'b1, 1'b0);
        #1;
        total++; if (BEQ_WRONG_PRED !== 1'b0) begin bad++; $display("FAIL stall bubble2 wrong: got %b want 0", BEQ_WRONG_PRED); end
        tick();
        drive(FILL, 32'h48, 1'b0, 1'b1, 1'b1);
        #1;
        total++; if (PRED_TAKEN_EX !== 1'b1) begin bad++; $display("FAIL stall held pred_ex: got %b want 1", PRED_TAKEN_EX); end
        total++; if (BEQ_WRONG_PRED !== 1'b0) begin bad++; $display("FAIL stall held wrong: got %b want 0", BEQ_WRONG_PRED); end
        tick();
        drive(32'h48, '0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (BRANCH_CNT !== 16'd7) begin bad++; $display("FAIL stall branch_cnt: got %0d want 7", BRANCH_CNT); end
        total++; if (MISPRED_CNT !== 16'd4) begin bad++; $display("FAIL stall mispred_cnt: got %0d want 4", MISPRED_CNT); end
        total++; if (PRED_TAKEN_IF !== 1'b1) begin bad++; $display("FAIL stall entry_st: got %b want 1", PRED_TAKEN_IF); end
    endtask

    task automatic test_flush_over_stall();
        drive(32'h40, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h48, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(FILL, 32'h40, 1'b1, 1'b1, 1'b1);
        #1;
        total++; if (BEQ_WRONG_PRED !== 1'b1) begin bad++; $display("FAIL flush wrong: got %b want 1", BEQ_WRONG_PRED); end
        tick();
        drive(FILL, 32'h48, 1'b0, 1'b1, 1'b0);
        #1;
        total++; if (PRED_TAKEN_EX !== 1'b0) begin bad++; $display("FAIL flush ex_cleared pred_ex: got %b want 0", PRED_TAKEN_EX); end
        total++; if (BEQ_WRONG_PRED !== 1'b0) begin bad++; $display("FAIL flush ex_cleared wrong: got %b want 0", BEQ_WRONG_PRED); end
        tick();
        drive(FILL, 32'h48, 1'b0, 1'b1, 1'b0);
        #1;
        total++; if (BEQ_WRONG_PRED !== 1'b0) begin bad++; $display("FAIL flush id_cleared wrong: got %b want 0", BEQ_WRONG_PRED); end
        tick();
        drive(32'h48, '0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (BRANCH_CNT !== 16'd8) begin bad++; $display("FAIL flush branch_cnt: got %0d want 8", BRANCH_CNT); end
        total++; if (MISPRED_CNT !== 16'd5) begin bad++; $display("FAIL flush mispred_cnt: got %0d want 5", MISPRED_CNT); end
        total++; if (PRED_TAKEN_IF !== 1'b1) begin bad++; $display("FAIL flush younger_untrained: got %b want 1", PRED_TAKEN_IF); end
        drive(32'h40, '0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (PRED_TAKEN_IF !== 1'b1) begin bad++; $display("FAIL flush trained_wt: got %b want 1", PRED_TAKEN_IF); end
    endtask

    task automatic test_alias_and_no_bypass();
        run_beq("alias80", 32'h80, 1'b0, 1'b1, 1'b1, 16'd9, 16'd6);
        drive(32'h40, '0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (PRED_TAKEN_IF !== 1'b0) begin bad++; $display("FAIL alias pred_40: got %b want 0", PRED_TAKEN_IF); end
        tick();
        drive(FILL, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h40, 32'h40, 1'b0, 1'b1, 1'b1);
        #1;
        total++; if (PRED_TAKEN_IF !== 1'b0) begin bad++; $display("FAIL nobypass pred_if: got %b want 0", PRED_TAKEN_IF); end
        total++; if (BEQ_WRONG_PRED !== 1'b1) begin bad++; $display("FAIL nobypass wrong: got %b want 1", BEQ_WRONG_PRED); end
        tick();
        drive(32'h40, '0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (PRED_TAKEN_IF !== 1'b1) begin bad++; $display("FAIL nobypass after: got %b want 1", PRED_TAKEN_IF); end
        total++; if (BRANCH_CNT !== 16'd10) begin bad++; $display("FAIL nobypass branch_cnt: got %0d want 10", BRANCH_CNT); end
        total++; if (MISPRED_CNT !== 16'd7) begin bad++; $display("FAIL nobypass mispred_cnt: got %0d want 7", MISPRED_CNT); end
    endtask

    task automatic test_async_reset();
        drive(32'h48, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(FILL, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h48, 32'h48, 1'b0, 1'b1, 1'b0);
        #1;
        total++; if (PRED_TAKEN_EX !== 1'b1) begin bad++; $display("FAIL areset inflight pred_ex: got %b want 1", PRED_TAKEN_EX); end
        RST = 1'b1;
        #1;
        total++; if (PRED_TAKEN_EX !== 1'b0) begin bad++; $display("FAIL areset pred_ex: got %b want 0", PRED_TAKEN_EX); end
        total++; if (BEQ_WRONG_PRED !== 1'b0) begin bad++; $display("FAIL areset wrong: got %b want 0", BEQ_WRONG_PRED); end
        total++; if (PRED_TAKEN_IF !== 1'b0) begin bad++; $display("FAIL areset table: got %b want 0", PRED_TAKEN_IF); end
        total++; if (BRANCH_CNT !== '0) begin bad++; $display("FAIL areset branch_cnt: got %0d want 0", BRANCH_CNT); end
        total++; if (MISPRED_CNT !== '0) begin bad++; $display("FAIL areset mispred_cnt: got %0d want 0", MISPRED_CNT); end
        RST = 1'b0;
        drive(32'h40, '0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (PRED_TAKEN_IF !== 1'b0) begin bad++; $display("FAIL areset table_40: got %b want 0", PRED_TAKEN_IF); end
        tick();
        run_beq("post_reset", 32'h40, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_train_taken();
        test_train_not_taken();
        test_stall();
        test_flush_over_stall();
        test_alias_and_no_bypass();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
